// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter.
// Holds the FSM state encoding, the default frame geometry and a helper that
// gives the accept-to-idle frame length in clocks.
package serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    localparam int unsigned DefDataW      = 8;
    localparam int unsigned DefClksPerBit = 4;

    // Clocks from the accept edge until the block is back in idle:
    // start bit + data bits + stop bit, each held for clks_per_bit clocks.
    function automatic int unsigned frame_clks(input int unsigned data_w,
                                               input int unsigned clks_per_bit);
        return (data_w + 2) * clks_per_bit;
    endfunction

    localparam int unsigned DefFrameClks = frame_clks(DefDataW, DefClksPerBit);

endpackage

// File: rtl/serial_baud_cnt.sv
// Baud counter for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the terminal count so the owner can
// advance to the next bit.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clear  holds the count at zero (and suppresses tick) while asserted
//   tick   high in the last clock of each bit period
module serial_baud_cnt
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == CntMax)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // With CLKS_PER_BIT=1 the count sits at zero and every clock is terminal.
    assign tick = !clear && (cnt_q == CntMax);

endmodule

// File: rtl/serial_tx_reg.sv
// Parallel-in, serial-out frame transmitter.
// Accepts a word over valid/ready and sends it as start bit (0), LSB-first
// data bits and stop bit (1), each bit held for CLKS_PER_BIT clocks.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any frame in progress
//   data   word to send, sampled when valid && ready at a rising edge
//   valid  word available
//   ready  block can accept a word (idle only)
//   txd    serial line, driven straight from a flop, idles high
//   busy   frame in progress
module serial_tx_reg
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              txd,
    output logic              busy
);

    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BitW-1:0]   bit_q;
    logic              txd_q;
    logic              tick;

    // Counter is held cleared in idle so every frame starts from a fresh bit
    // period on the cycle after accept.
    serial_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == StIdle),
        .tick (tick)
    );

    // txd is loaded one bit ahead on each transition so the new level appears
    // together with the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (valid && ready) begin
                        shift_q <= data;
                        bit_q   <= '0;
                        txd_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_q == BitMax) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + BitW'(1);
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign txd   = txd_q;
    assign ready = (state_q == StIdle);
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx_reg.sv
module tb_serial_tx_reg;
    import serial_pkg::*;

    localparam int unsigned DW        = 8;
    localparam int unsigned CPB       = 4;
    localparam int unsigned FrameBits = DW + 2;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          txd;
    logic          busy;

    logic [0:0]    data_e;
    logic          valid_e;
    logic          ready_e;
    logic          txd_e;
    logic          busy_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit sb_q[$];

    serial_tx_reg #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .data (data),
        .valid(valid),
        .ready(ready),
        .txd  (txd),
        .busy (busy)
    );

    serial_tx_reg #(
        .DATA_W      (1),
        .CLKS_PER_BIT(1)
    ) dut_min (
        .clk  (clk),
        .rst_n(rst_n),
        .data (data_e),
        .valid(valid_e),
        .ready(ready_e),
        .txd  (txd_e),
        .busy (busy_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_bit({tag, "_txd"}, txd, 1'b1);
        check_bit({tag, "_ready"}, ready, 1'b1);
        check_bit({tag, "_busy"}, busy, 1'b0);
    endtask

    // Expected line levels for one frame: start, LSB-first data, stop.
    task automatic push_frame(input logic [DW-1:0] d);
        sb_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) sb_q.push_back(d[i]);
        sb_q.push_back(1'b1);
    endtask

    // Called #1 after the accept edge. Pops one expected level per bit and
    // checks it on every clock of the bit period. inject_bit drives new
    // data/valid during that bit; abort_bit resets the DUT during that bit.
    task automatic expect_frame(input int inject_bit, input int abort_bit,
                                output int stop_cyc);
        logic exp;
        stop_cyc = 0;
        for (int b = 0; b < FrameBits; b++) begin
            total++;
            assert (sb_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_underflow observed=%0d expected=>0", sb_q.size());
                return;
            end
            exp = sb_q.pop_front();
            if (b == FrameBits - 1) stop_cyc = cyc;
            for (int c = 0; c < CPB; c++) begin
                if (b == abort_bit && c == 1) begin
                    rst_n = 1'b0;
                    #2;
                    check_idle("abort_async");
                    sb_q.delete();
                    #2;
                    rst_n = 1'b1;
                    step();
                    return;
                end
                if (b == inject_bit && c == 1) begin
                    data  = 8'h3C;
                    valid = 1'b1;
                end
                if (b == inject_bit && c == 2) valid = 1'b0;
                check_bit($sformatf("txd_b%0d_c%0d", b, c), txd, exp);
                check_bit($sformatf("busy_b%0d_c%0d", b, c), busy, 1'b1);
                check_bit($sformatf("ready_b%0d_c%0d", b, c), ready, 1'b0);
                step();
            end
        end
    endtask

    initial begin
        int acc_cyc;
        int stop1;
        int start2;
        int dummy;

        rst_n   = 1'b1;
        data    = '0;
        valid   = 1'b0;
        data_e  = '0;
        valid_e = 1'b0;

        // Asynchronous reset before the first clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_idle("reset");
        check_bit("reset_min_txd", txd_e, 1'b1);
        check_bit("reset_min_ready", ready_e, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("idle_no_valid");
        end

        // Single frame 8'hA5.
        data  = 8'hA5;
        valid = 1'b1;
        push_frame(8'hA5);
        step();
        valid   = 1'b0;
        acc_cyc = cyc;
        expect_frame(-1, -1, dummy);
        check_idle("a5_end");
        check_int("a5_frame_len", cyc - acc_cyc, int'(frame_clks(DW, CPB)));

        // Mid-frame data change and valid pulse are ignored.
        data  = 8'hC3;
        valid = 1'b1;
        push_frame(8'hC3);
        step();
        valid = 1'b0;
        expect_frame(4, -1, dummy);
        for (int i = 0; i < 6; i++) begin
            check_idle("no_second_frame");
            step();
        end

        // Back-to-back with valid held high.
        data  = 8'h00;
        valid = 1'b1;
        push_frame(8'h00);
        step();
        data = 8'hFF;
        push_frame(8'hFF);
        expect_frame(-1, -1, stop1);
        check_bit("b2b_gap_txd", txd, 1'b1);
        check_bit("b2b_gap_ready", ready, 1'b1);
        step();
        valid  = 1'b0;
        start2 = cyc;
        check_int("b2b_gap_len", start2 - stop1, int'(CPB) + 1);
        expect_frame(-1, -1, dummy);
        check_idle("b2b_end");

        // Reset during data bit 3, then a clean frame.
        data  = 8'h5A;
        valid = 1'b1;
        push_frame(8'h5A);
        step();
        valid = 1'b0;
        expect_frame(-1, 4, dummy);
        check_idle("post_abort");
        check_int("post_abort_sb_empty", sb_q.size(), 0);
        data  = 8'h81;
        valid = 1'b1;
        push_frame(8'h81);
        step();
        valid = 1'b0;
        expect_frame(-1, -1, dummy);
        check_idle("x81_end");

        // DATA_W=1, CLKS_PER_BIT=1 instance.
        data_e  = 1'b1;
        valid_e = 1'b1;
        step();
        valid_e = 1'b0;
        check_bit("min_start_txd", txd_e, 1'b0);
        check_bit("min_start_busy", busy_e, 1'b1);
        check_bit("min_start_ready", ready_e, 1'b0);
        step();
        check_bit("min_data_txd", txd_e, 1'b1);
        check_bit("min_data_busy", busy_e, 1'b1);
        step();
        check_bit("min_stop_txd", txd_e, 1'b1);
        check_bit("min_stop_busy", busy_e, 1'b1);
        step();
        check_bit("min_end_ready", ready_e, 1'b1);
        check_bit("min_end_busy", busy_e, 1'b0);
        check_bit("min_end_txd", txd_e, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
